// File: rtl/muldiv_if.sv
// muldiv_if -- request/response bundle for the iterative multiply/divide unit.
//
// Signals:
//   start     requester -> unit : begin a new operation (honoured only when idle)
//   fn        requester -> unit : RV32M funct3 operation select
//   v1, v2    requester -> unit : operands rs1 / rs2
//   busy      unit -> requester : an operation is in flight
//   done      unit -> requester : one-cycle pulse, out carries a fresh result
//   out       unit -> requester : registered 32-bit result
//   zero      unit -> requester : out is all zeros
//   negative  unit -> requester : sign bit of out
interface muldiv_if;
  logic        start;
  logic [2:0]  fn;
  logic [31:0] v1;
  logic [31:0] v2;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        zero;
  logic        negative;

  modport master (
    output start, fn, v1, v2,
    input  busy, done, out, zero, negative
  );

  modport slave (
    input  start, fn, v1, v2,
    output busy, done, out, zero, negative
  );
endinterface

// File: rtl/muldiv.sv
// muldiv -- RV32M multiply/divide unit, one radix-2 step per clock.
//
// Every operation takes the same 33 edges from the accepting edge to the
// result: 32 RUN steps on unsigned magnitudes, then one FINISH cycle that
// applies the sign and registers the result.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; aborts any operation in flight
//   bus   muldiv_if slave side (start/fn/v1/v2 in, busy/done/out/zero/negative out)
module muldiv (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  fn_q;
  logic [31:0] opb;
  logic [63:0] acc;
  logic [4:0]  count;
  logic        neg_res;
  logic        done_q;
  logic [31:0] out_q;

  logic        v1_signed;
  logic        v2_signed;
  logic        s1;
  logic        s2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        neg_start;
  logic [63:0] acc_init;
  logic [31:0] opb_init;

  // Operand preparation at the accepting edge.  Multiplies keep the
  // multiplier in the low half of acc and shift it out as the product
  // grows in; divides keep the dividend there and shift quotient bits in.
  // A signed divide by zero must come out as all ones, so the quotient is
  // never negated in that case.
  always_comb begin
    v1_signed = 1'b0;
    v2_signed = 1'b0;
    case (bus.fn)
      3'd1, 3'd4, 3'd6: begin
        v1_signed = 1'b1;
        v2_signed = 1'b1;
      end
      3'd2:    v1_signed = 1'b1;
      default: ;
    endcase

    s1   = v1_signed & bus.v1[31];
    s2   = v2_signed & bus.v2[31];
    mag1 = s1 ? (32'd0 - bus.v1) : bus.v1;
    mag2 = s2 ? (32'd0 - bus.v2) : bus.v2;

    neg_start = 1'b0;
    case (bus.fn)
      3'd1, 3'd2: neg_start = s1 ^ s2;
      3'd4:       neg_start = (bus.v2 != 32'd0) & (s1 ^ s2);
      3'd6:       neg_start = s1;
      default:    neg_start = 1'b0;
    endcase

    if (bus.fn[2]) begin
      acc_init = {32'd0, mag1};
      opb_init = mag2;
    end else begin
      acc_init = {32'd0, mag2};
      opb_init = mag1;
    end
  end

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_next;

  // One iteration of each algorithm.  The multiply adds the multiplicand
  // into the high half when the current multiplier bit is set, then shifts
  // the whole 65-bit sum right.  The divide is restoring: shift the
  // partial remainder left, try the subtraction, and keep it only when it
  // does not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, opb};
    if (div_diff[32]) begin
      div_next = {div_shift[31:0], acc[30:0], 1'b0};
    end else begin
      div_next = {div_diff[31:0], acc[30:0], 1'b1};
    end
  end

  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] result;

  // Sign correction and result selection used in FINISH.  After a divide,
  // acc holds {remainder, quotient}; after a multiply, the full product.
  always_comb begin
    prod_fix = neg_res ? (64'd0 - acc) : acc;
    quo_fix  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fix  = neg_res ? (32'd0 - acc[63:32]) : acc[63:32];
    case (fn_q)
      3'd0:             result = prod_fix[31:0];
      3'd1, 3'd2, 3'd3: result = prod_fix[63:32];
      3'd4, 3'd5:       result = quo_fix;
      default:          result = rem_fix;
    endcase
  end

  // Control FSM and datapath registers.  done is cleared every cycle and
  // only set on the FINISH edge, which makes it a single-cycle pulse; the
  // unit is already back in IDLE while done is high, so a start in that
  // cycle is accepted immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fn_q    <= 3'd0;
      opb     <= 32'd0;
      acc     <= 64'd0;
      count   <= 5'd0;
      neg_res <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            fn_q    <= bus.fn;
            opb     <= opb_init;
            acc     <= acc_init;
            neg_res <= neg_start;
            count   <= 5'd0;
            state   <= RUN;
          end
        end
        RUN: begin
          acc   <= fn_q[2] ? div_next : mul_next;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          out_q  <= result;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.out      = out_q;
  assign bus.zero     = (out_q == 32'd0);
  assign bus.negative = out_q[31];

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv -- self-checking bench for the muldiv unit.
//
// Drives the unit through a muldiv_if instance: a table of known results,
// randomized operations against an arithmetic reference, and hand-written
// sequences for reset, back-to-back starts and mid-operation abort.
module tb_muldiv;

  logic clk;
  logic rst;

  muldiv_if bus ();

  muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int assert_count = 0;
  int fail_count   = 0;

  typedef struct {
    string       name;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the whole run somehow stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance past the next rising edge; outputs are sampled and inputs are
  // changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // RV32M result computed directly from the instruction definitions.
  function automatic logic [31:0] refModel(input logic [2:0] fn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    int          ia;
    int          ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (fn)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * ub;                 return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Wait up to 40 edges for done.  edges is the edge count at which done
  // was seen (-1 on timeout); busy_ok tracks that busy stayed high before
  // done and dropped together with it.  With scramble set, the request
  // inputs are randomized every cycle while the unit is working.
  task automatic waitDone(input bit scramble, output int edges, output bit busy_ok);
    edges   = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        edges = k;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (scramble) begin
        bus.fn = 3'($urandom_range(0, 7));
        bus.v1 = $urandom;
        bus.v2 = $urandom;
      end
    end
  endtask

  task automatic checkResult(input string name, input logic [31:0] exp,
                             input int edges, input bit busy_ok);
    checkOutput({name, " latency"}, 32'(edges), 32'd33);
    checkOutput({name, " busy"}, {31'd0, busy_ok}, 32'd1);
    checkOutput({name, " out"}, bus.out, exp);
    checkOutput({name, " zero"}, {31'd0, bus.zero}, {31'd0, exp == 32'd0});
    checkOutput({name, " negative"}, {31'd0, bus.negative}, {31'd0, exp[31]});
  endtask

  // Issue one operation from IDLE, scramble inputs while it runs, and
  // verify timing, result, flags, the single-cycle done and the hold of out.
  task automatic applyStimulus(input string name, input logic [2:0] fn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp);
    int edges;
    bit busy_ok;
    for (int k = 0; k < 40 && bus.busy === 1'b1; k++) tick();
    bus.start = 1'b1;
    bus.fn    = fn;
    bus.v1    = a;
    bus.v2    = b;
    tick();
    bus.start = 1'b0;
    waitDone(1'b1, edges, busy_ok);
    checkResult(name, exp, edges, busy_ok);
    tick();
    checkOutput({name, " done pulse"}, {31'd0, bus.done}, 32'd0);
    checkOutput({name, " out hold"}, bus.out, exp);
  endtask

  initial begin
    vec_t vecs[13];
    int   edges;
    bit   busy_ok;
    bit   no_done;

    vecs[0]  = '{"MUL 7*-3",          3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{"MULHU -1*-1",       3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{"MULH -1*-1",        3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{"MULHSU -1*2",       3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{"DIV -7/2",          3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{"REM -7/2",          3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{"DIVU big/2",        3'd5, 32'hFFFF_FFFE,  32'd2,         32'h7FFF_FFFF};
    vecs[7]  = '{"DIV 5/0",           3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[8]  = '{"REMU 5/0",          3'd7, 32'd5,          32'd0,         32'd5};
    vecs[9]  = '{"DIV overflow",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[10] = '{"REM overflow",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    vecs[11] = '{"DIVU 5/0",          3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[12] = '{"REM -5/0",          3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.fn    = 3'd0;
    bus.v1    = 32'd0;
    bus.v2    = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset out", bus.out, 32'd0);
    checkOutput("reset zero", {31'd0, bus.zero}, 32'd1);
    checkOutput("reset negative", {31'd0, bus.negative}, 32'd0);

    // Start held through reset: ignored while rst is high, taken on the
    // first edge after rst falls.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.fn    = 3'd0;
    bus.v1    = 32'd3;
    bus.v2    = 32'd4;
    tick();
    checkOutput("rst over start busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    tick();
    bus.start = 1'b0;
    checkOutput("first edge start busy", {31'd0, bus.busy}, 32'd1);
    waitDone(1'b1, edges, busy_ok);
    checkResult("first edge MUL 3*4", 32'd12, edges, busy_ok);
    tick();

    $display("[TB] table vectors");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].name, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    $display("[TB] randomized operations");
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  rfn;
      logic [31:0] ra;
      logic [31:0] rb;
      rfn = 3'($urandom_range(0, 7));
      ra  = pickOperand();
      rb  = pickOperand();
      applyStimulus($sformatf("rand%0d fn%0d %h,%h", i, rfn, ra, rb),
                    rfn, ra, rb, refModel(rfn, ra, rb));
    end

    // Start held high: accepted from IDLE, then again on the done cycle.
    $display("[TB] held start");
    bus.start = 1'b1;
    bus.fn    = 3'd0;
    bus.v1    = 32'd2;
    bus.v2    = 32'd3;
    tick();
    bus.v1 = 32'd5;
    bus.v2 = 32'd7;
    waitDone(1'b0, edges, busy_ok);
    checkResult("held op1", 32'd6, edges, busy_ok);
    tick();
    checkOutput("held reaccept busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("held reaccept done", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b0;
    waitDone(1'b0, edges, busy_ok);
    checkResult("held op2", 32'd35, edges, busy_ok);
    tick();

    // Reset ten edges into an operation, restart two edges later.
    $display("[TB] mid-operation reset");
    no_done   = 1'b1;
    bus.start = 1'b1;
    bus.fn    = 3'd5;
    bus.v1    = 32'd100;
    bus.v2    = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (bus.done !== 1'b0) no_done = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort out", bus.out, 32'd0);
    checkOutput("abort done", {31'd0, bus.done}, 32'd0);
    tick();
    if (bus.done !== 1'b0) no_done = 1'b0;
    checkOutput("abort no done", {31'd0, no_done}, 32'd1);
    bus.start = 1'b1;
    bus.fn    = 3'd0;
    bus.v1    = 32'd6;
    bus.v2    = 32'd7;
    tick();
    bus.start = 1'b0;
    waitDone(1'b1, edges, busy_ok);
    checkResult("restart MUL 6*7", 32'd42, edges, busy_ok);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port fn, input, 3 bits: operation select using RV32M funct3 encoding, sampled with start.
REQ-005 SHALL have port v1, input, 32 bits: operand rs1, sampled with start.
REQ-006 SHALL have port v2, input, 32 bits: operand rs2, sampled with start.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking out valid.
REQ-009 SHALL have port out, output, 32 bits: registered result, held until the next accepted start or reset.
REQ-010 SHALL have port zero, output, 1 bit: high when out == 0, derived from registered out.
REQ-011 SHALL have port negative, output, 1 bit: equals out[31].

Function
REQ-012 SHALL decode fn as follows: 0 MUL (low 32 bits); 1 MULH (signed x signed, high 32 bits); 2 MULHSU (signed v1 x unsigned v2, high); 3 MULHU (unsigned x unsigned, high); 4 DIV; 5 DIVU; 6 REM; 7 REMU.
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, FINISH.
REQ-014 SHALL, in IDLE with start=1 at edge N, latch fn, v1 and v2, take operand magnitudes and result sign, clear the 5-bit iteration counter, and enter RUN.
REQ-015 SHALL perform exactly one shift-add (multiply) or one restoring shift-subtract (divide) step per RUN cycle, for 32 steps.
REQ-016 SHALL, when the counter equals 31 in RUN, enter FINISH at that edge (edge N+32).
REQ-017 SHALL, in FINISH, apply sign correction, register out, assert done for exactly one cycle, and return to IDLE at edge N+33.
REQ-018 SHALL have a fixed latency for all fn and operand values: done is high in the cycle following edge N+33.
REQ-019 SHALL accept a new start in the same cycle that done is high; that start is treated as edge N of the next operation.
REQ-020 SHALL ignore start while busy=1; fn, v1 and v2 changes during RUN and FINISH SHALL have no effect.
REQ-021 SHALL keep the 64-bit product internal; only the selected 32-bit half appears on out.
REQ-022 SHALL, on division by zero, produce DIV/DIVU = 0xFFFFFFFF and REM/REMU = v1, with no trap and the same latency.
REQ-023 SHALL, for signed overflow (v1 = 0x80000000, v2 = 0xFFFFFFFF), produce DIV = 0x80000000 and REM = 0.
REQ-024 SHALL give the remainder of signed division the sign of v1 and truncate the quotient toward zero.

Reset
REQ-025 SHALL, on any edge with rst=1, force IDLE and set busy=0, done=0, out=0 and counter=0; zero is then 1 and negative is 0.
REQ-026 SHALL treat rst taking priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-027 SHALL accept start on the first edge with rst=0 after reset.

Verification
REQ-028 SHALL cover MUL: v1=7, v2=-3 (0xFFFFFFFD), start at edge N -> busy high on edges N+1..N+33, done high after edge N+33, out=0xFFFFFFEB, negative=1.
REQ-029 SHALL cover the high-half multiplies: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> out=0xFFFFFFFE; MULH with the same operands -> out=0x00000000 and zero=1; MULHSU v1=0xFFFFFFFF, v2=2 -> out=0xFFFFFFFF.
REQ-030 SHALL cover signed divide: DIV -7/2 -> out=0xFFFFFFFD (-3); REM -7/2 -> out=0xFFFFFFFF (-1); DIVU 0xFFFFFFFE/2 -> out=0x7FFFFFFF.
REQ-031 SHALL cover the corner cases: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; all with 33-cycle latency.
REQ-032 SHALL cover handshake timing: start held high continuously -> operations are accepted only on the edge when done is high and on the initial IDLE edge; operand changes during RUN do not alter out.
REQ-033 SHALL cover mid-operation reset: rst=1 at edge N+10 -> busy=0, out=0 and no done; a subsequent start at edge N+12 completes normally 33 edges later.
